// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// the dmem byte-address width and the address legality check.
package dmem_responder_pkg;

  localparam int DMEM_AW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

  // A byte address is illegal when it is not word aligned, or when any bit
  // above the SRAM word-address field is set (only possible for aw < 14).
  function automatic logic addr_bad(input logic [DMEM_AW-1:0] a, input int aw);
    logic [DMEM_AW-1:0] hi;
    hi = a >> (aw + 2);
    return (a[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_arb.sv
// Two-input fixed-priority arbiter. The high-priority input always wins the
// combinational pick; the grant is latched only when lat_en is high so it
// stays fixed for the whole transaction.
module dmem_arb (
  input  logic clk,
  input  logic resetn,
  input  logic req_hi,
  input  logic req_lo,
  input  logic lat_en,
  output logic any_req,
  output logic pick_hi,
  output logic gnt_hi_q
);

  assign any_req = req_hi | req_lo;
  assign pick_hi = req_hi;

  // Hold the granted port from the IDLE sample until the next sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_hi_q <= 1'b0;
    end else if (lat_en) begin
      gnt_hi_q <= pick_hi;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: arbitrates the stack port (priority) and the core
// load/store port onto a single-port synchronous SRAM with RD_LAT cycles of
// read latency, and finishes every transaction with a one-cycle ack.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_req,
  input  logic              st_wr,
  input  logic [15:0]       st_addr,
  input  logic [31:0]       st_wdata,
  input  logic              core_req,
  input  logic              core_wr,
  input  logic [15:0]       core_addr,
  input  logic [31:0]       core_wdata,
  output logic              st_ack,
  output logic              core_ack,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
    $error("dmem_responder: RD_LAT must be in 1..4");
  end
  if ((ADDR_W < 1) || (ADDR_W > 14)) begin : g_bad_addr_w
    $error("dmem_responder: ADDR_W must be in 1..14");
  end

  localparam logic [1:0] WCNT_LAST = 2'(RD_LAT - 1);

  dmem_state_t          state, state_nxt;
  logic [1:0]           wcnt;
  logic                 wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          wdata_q;
  logic                 err_q;

  logic                 any_req;
  logic                 pick_st;
  logic                 gnt_st_q;
  logic                 sample;
  logic                 sel_wr;
  logic [DMEM_AW-1:0]   sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_bad;

  dmem_arb u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .req_hi   (st_req),
    .req_lo   (core_req),
    .lat_en   (sample),
    .any_req  (any_req),
    .pick_hi  (pick_st),
    .gnt_hi_q (gnt_st_q)
  );

  assign sample    = (state == IDLE) && any_req;
  assign sel_wr    = pick_st ? st_wr    : core_wr;
  assign sel_addr  = pick_st ? st_addr  : core_addr;
  assign sel_wdata = pick_st ? st_wdata : core_wdata;
  assign sel_bad   = addr_bad(sel_addr, ADDR_W);

  assign stall      = any_req & ~(st_ack | core_ack);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  // State register; reset aborts any transaction without an ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read-latency counter, running only while in WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt <= 2'd0;
    end else if ((state == WAIT) && (wcnt != WCNT_LAST)) begin
      wcnt <= wcnt + 2'd1;
    end else begin
      wcnt <= 2'd0;
    end
  end

  // Request latches: captured once at the IDLE sample, ignored afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (sample) begin
      wr_q    <= sel_wr;
      addr_q  <= sel_addr[ADDR_W+1:2];
      wdata_q <= sel_wdata;
      err_q   <= sel_bad;
    end
  end

  // Read data register, loaded on the last WAIT cycle only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= 32'd0;
    end else if ((state == WAIT) && (wcnt == WCNT_LAST)) begin
      rdata <= sram_rdata;
    end
  end

  // Next-state and per-state outputs; illegal addresses bypass the SRAM.
  always_comb begin
    state_nxt = state;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    st_ack    = 1'b0;
    core_ack  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = sel_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        sram_cs   = 1'b1;
        sram_we   = wr_q;
        state_nxt = wr_q ? RESP : WAIT;
      end
      WAIT: begin
        if (wcnt == WCNT_LAST) state_nxt = RESP;
      end
      RESP: begin
        st_ack    = gnt_st_q;
        core_ack  = ~gnt_st_q;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with RD_LAT=2 and a behavioural SRAM.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int AW  = 14;

  logic          clk = 1'b0;
  logic          resetn;
  logic          st_req, st_wr, core_req, core_wr;
  logic [15:0]   st_addr, core_addr;
  logic [31:0]   st_wdata, core_wdata;
  logic          st_ack, core_ack, stall, err, sram_cs, sram_we;
  logic [31:0]   rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;

  int checks = 0;
  int failures = 0;
  int st_acks = 0;
  int core_acks = 0;
  int st_save, core_save;

  always #5 clk = ~clk;

  dmem_responder #(.RD_LAT(LAT), .ADDR_W(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .st_req     (st_req),
    .st_wr      (st_wr),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .core_req   (core_req),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .st_ack     (st_ack),
    .core_ack   (core_ack),
    .stall      (stall),
    .rdata      (rdata),
    .err        (err),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural SRAM: read data appears LAT cycles after the select edge.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rpipe [0:LAT-1];
  always @(posedge clk) begin
    if (sram_cs && !sram_we) rpipe[0] <= mem[sram_addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
  end
  assign sram_rdata = rpipe[LAT-1];

  // Ack pulse counters.
  always @(posedge clk) begin
    if (st_ack)   st_acks   <= st_acks + 1;
    if (core_ack) core_acks <= core_acks + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction starting in an IDLE cycle; checks ack latency,
  // err and (for reads) rdata, then releases the request.
  task automatic do_txn(input bit port_st, input bit wr, input logic [15:0] a,
                        input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_rd, input string tag);
    int n;
    if (port_st) begin
      st_req = 1'b1; st_wr = wr; st_addr = a; st_wdata = wd;
    end else begin
      core_req = 1'b1; core_wr = wr; core_addr = a; core_wdata = wd;
    end
    n = 0;
    #1;
    while (!(port_st ? st_ack : core_ack) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    if (!wr) chk({tag, "_rdata"}, rdata, exp_rd);
    st_req = 1'b0;
    core_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    st_req = 1'b0; st_wr = 1'b0; st_addr = 16'h0; st_wdata = 32'h0;
    core_req = 1'b0; core_wr = 1'b0; core_addr = 16'h0; core_wdata = 32'h0;
    #2;
    chk("rst_cs",    {31'd0, sram_cs},  32'd0);
    chk("rst_we",    {31'd0, sram_we},  32'd0);
    chk("rst_ack",   {30'd0, st_ack, core_ack}, 32'd0);
    chk("rst_err",   {31'd0, err},      32'd0);
    chk("rst_rdata", rdata,             32'd0);
    chk("rst_stall", {31'd0, stall},    32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Stack write to 0x7FFC.
    core_save = core_acks;
    st_req = 1'b1; st_wr = 1'b1; st_addr = 16'h7FFC; st_wdata = 32'hDEADBEEF;
    #1;
    chk("t1_c0_stall", {31'd0, stall},   32'd1);
    chk("t1_c0_cs",    {31'd0, sram_cs}, 32'd0);
    tick();
    chk("t1_c1_cs",    {31'd0, sram_cs}, 32'd1);
    chk("t1_c1_we",    {31'd0, sram_we}, 32'd1);
    chk("t1_c1_addr",  32'(sram_addr),   32'h1FFF);
    chk("t1_c1_wdata", sram_wdata,       32'hDEADBEEF);
    chk("t1_c1_ack",   {31'd0, st_ack},  32'd0);
    tick();
    chk("t1_c2_stack", {31'd0, st_ack},   32'd1);
    chk("t1_c2_core",  {31'd0, core_ack}, 32'd0);
    chk("t1_c2_err",   {31'd0, err},      32'd0);
    chk("t1_c2_stall", {31'd0, stall},    32'd0);
    st_req = 1'b0; st_wr = 1'b0;
    tick();
    chk("t1_c3_ack",   {31'd0, st_ack},   32'd0);
    chk("t1_core_cnt", 32'(core_acks), 32'(core_save));

    // Preload word 4 through the core port, then read it back with RD_LAT=2.
    do_txn(1'b0, 1'b1, 16'h0010, 32'h12345678, 2, 32'h0, "pre_wr");
    core_req = 1'b1; core_wr = 1'b0; core_addr = 16'h0010;
    #1;
    chk("t2_c0_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("t2_c1_cs",    {31'd0, sram_cs}, 32'd1);
    chk("t2_c1_we",    {31'd0, sram_we}, 32'd0);
    chk("t2_c1_addr",  32'(sram_addr),   32'h4);
    chk("t2_c1_stall", {31'd0, stall},   32'd1);
    tick();
    chk("t2_c2_stall", {31'd0, stall},    32'd1);
    tick();
    chk("t2_c3_stall", {31'd0, stall},    32'd1);
    chk("t2_c3_ack",   {31'd0, core_ack}, 32'd0);
    tick();
    chk("t2_c4_ack",   {31'd0, core_ack}, 32'd1);
    chk("t2_c4_rdata", rdata,             32'h12345678);
    chk("t2_c4_stall", {31'd0, stall},    32'd0);
    chk("t2_c4_stack", {31'd0, st_ack},   32'd0);
    core_req = 1'b0;
    tick();

    // Simultaneous writes: stack first, core after one IDLE cycle.
    st_req = 1'b1; st_wr = 1'b1; st_addr = 16'h0100; st_wdata = 32'hA5A5A5A5;
    core_req = 1'b1; core_wr = 1'b1; core_addr = 16'h0200; core_wdata = 32'h5A5A5A5A;
    tick();
    chk("t3_c1_addr",  32'(sram_addr), 32'h40);
    chk("t3_c1_wdata", sram_wdata,     32'hA5A5A5A5);
    tick();
    chk("t3_c2_stack", {31'd0, st_ack},   32'd1);
    chk("t3_c2_core",  {31'd0, core_ack}, 32'd0);
    st_req = 1'b0; st_wr = 1'b0;
    tick();
    chk("t3_c3_cs",    {31'd0, sram_cs}, 32'd0);
    chk("t3_c3_stall", {31'd0, stall},   32'd1);
    tick();
    chk("t3_c4_cs",    {31'd0, sram_cs}, 32'd1);
    chk("t3_c4_addr",  32'(sram_addr),   32'h80);
    chk("t3_c4_wdata", sram_wdata,       32'h5A5A5A5A);
    tick();
    chk("t3_c5_core",  {31'd0, core_ack}, 32'd1);
    chk("t3_c5_stack", {31'd0, st_ack},   32'd0);
    core_req = 1'b0; core_wr = 1'b0;
    tick();

    // Misaligned stack read.
    st_req = 1'b1; st_wr = 1'b0; st_addr = 16'h0002;
    #1;
    chk("t4_c0_cs",    {31'd0, sram_cs}, 32'd0);
    tick();
    chk("t4_c1_ack",   {31'd0, st_ack},  32'd1);
    chk("t4_c1_err",   {31'd0, err},     32'd1);
    chk("t4_c1_cs",    {31'd0, sram_cs}, 32'd0);
    chk("t4_c1_rdata", rdata,            32'h12345678);
    st_req = 1'b0;
    tick();
    chk("t4_c2_err",   {31'd0, err},     32'd0);
    chk("t4_c2_ack",   {31'd0, st_ack},  32'd0);

    // Reset during WAIT, then a fresh read.
    st_req = 1'b1; st_wr = 1'b0; st_addr = 16'h7FFC;
    tick();
    chk("t5_c1_cs", {31'd0, sram_cs}, 32'd1);
    tick();
    st_save = st_acks;
    resetn = 1'b0;
    st_req = 1'b0;
    #1;
    chk("t5_rst_cs",    {31'd0, sram_cs}, 32'd0);
    chk("t5_rst_we",    {31'd0, sram_we}, 32'd0);
    chk("t5_rst_ack",   {30'd0, st_ack, core_ack}, 32'd0);
    chk("t5_rst_err",   {31'd0, err},     32'd0);
    chk("t5_rst_rdata", rdata,            32'd0);
    chk("t5_rst_stall", {31'd0, stall},   32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("t5_no_ack", 32'(st_acks), 32'(st_save));
    do_txn(1'b1, 1'b0, 16'h7FFC, 32'h0, 4, 32'hDEADBEEF, "t5_rd");

    // Core drops its request after the sample; the write still completes.
    core_req = 1'b1; core_wr = 1'b1; core_addr = 16'h0020; core_wdata = 32'hCAFEF00D;
    tick();
    core_req = 1'b0;
    tick();
    chk("t7_c2_ack", {31'd0, core_ack}, 32'd1);
    tick();
    do_txn(1'b0, 1'b0, 16'h0020, 32'h0, 4, 32'hCAFEF00D, "t7_rd");

    // PUSH/POP: three stack writes, then read back in reverse order.
    st_save = st_acks;
    core_save = core_acks;
    do_txn(1'b1, 1'b1, 16'h7FFC, 32'h11111111, 2, 32'h0, "push0");
    do_txn(1'b1, 1'b1, 16'h7FF8, 32'h22222222, 2, 32'h0, "push1");
    do_txn(1'b1, 1'b1, 16'h7FF4, 32'h33333333, 2, 32'h0, "push2");
    do_txn(1'b1, 1'b0, 16'h7FF4, 32'h0, 4, 32'h33333333, "pop2");
    do_txn(1'b1, 1'b0, 16'h7FF8, 32'h0, 4, 32'h22222222, "pop1");
    do_txn(1'b1, 1'b0, 16'h7FFC, 32'h0, 4, 32'h11111111, "pop0");
    chk("pp_st_acks",   32'(st_acks - st_save),     32'd6);
    chk("pp_core_acks", 32'(core_acks - core_save), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
